// File: rtl/logic_op_pkg.sv
// Shared opcode definitions for the registered bitwise logic unit.
// Included by the ALU, the interface and the top level.
package logic_op_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_NOTA = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op_unit_if.sv
// Operand/result handshake bundle for logic_op_unit.
// master drives operands and out_ready; slave is the unit.
interface logic_op_unit_if
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [OPCODE_W-1:0] in_op;
    logic                in_acc;
    logic                acc_clr;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [CNT_W-1:0]    txn_cnt;
    logic                out_zero;
    logic                out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, txn_cnt, out_zero, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_data, txn_cnt, out_zero, out_parity
    );

endinterface

// File: rtl/logic_op_alu.sv
// Combinational WIDTH-bit bitwise operation select.
// Pure function of (a, b, op); no state.
module logic_op_alu
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_ANDN: y_o = a_i & ~b_i;
            OP_NOTA: y_o = ~a_i;
        endcase
    end

endmodule

// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit with accumulator and transfer counter.
// Define LOGIC_OP_FLAGS_EN to build the registered zero/parity flags.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    logic_op_unit_if.slave bus
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             xfer;

    assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = (state_q == ST_FULL) && bus.out_ready;

    // A same-cycle clear makes a chained operation start from zero.
    always_comb begin
        op_a = bus.in_a;
        if (bus.in_acc) begin
            op_a = bus.acc_clr ? '0 : acc_q;
        end
    end

    logic_op_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a_i (op_a),
        .b_i (bus.in_b),
        .op_i(op_e'(bus.in_op)),
        .y_o (result)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        acc_d   = acc_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = result;
            acc_d   = result;
        end else begin
            if (xfer) begin
                state_d = ST_EMPTY;
            end
            if (bus.acc_clr) begin
                acc_d = '0;
            end
        end
    end

    assign cnt_d = cnt_q + CNT_W'(xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.txn_cnt   = cnt_q;

`ifdef LOGIC_OP_FLAGS_EN
    logic zero_q, zero_d;
    logic par_q, par_d;

    assign zero_d = accept ? (result == '0) : zero_q;
    assign par_d  = accept ? (^result) : par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            par_q  <= par_d;
        end
    end

    assign bus.out_zero   = zero_q;
    assign bus.out_parity = par_q;
`else
    assign bus.out_zero   = 1'b0;
    assign bus.out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit: directed vectors, queued expectations.
// A 4-bit-counter twin shares the stimulus to exercise counter wrap.
module tb_logic_op_unit;
    import logic_op_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_op_unit_if #(.WIDTH(8), .CNT_W(8)) bus ();
    logic_op_unit_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

    logic_op_unit #(.WIDTH(8), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic_op_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_a      = bus.in_a;
    assign bus4.in_b      = bus.in_b;
    assign bus4.in_op     = bus.in_op;
    assign bus4.in_acc    = bus.in_acc;
    assign bus4.acc_clr   = bus.acc_clr;
    assign bus4.out_ready = bus.out_ready;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       p;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int retries = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d);
        exp_t r;
        r.d = d;
`ifdef LOGIC_OP_FLAGS_EN
        r.z = (d == 8'h00);
        r.p = ^d;
`else
        r.z = 1'b0;
        r.p = 1'b0;
`endif
        return r;
    endfunction

    // Monitor: counter tracking plus in-order result checking.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            n_xfer = 0;
            q.delete();
        end else begin
            chk("txn_cnt", 32'(bus.txn_cnt), 32'(n_xfer[7:0]));
            chk("txn_cnt4", 32'(bus4.txn_cnt), 32'(n_xfer[3:0]));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none",
                             bus.out_data);
                end else begin
                    e = q[0];
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_zero", 32'(bus.out_zero), 32'(e.z));
                    chk("out_parity", 32'(bus.out_parity), 32'(e.p));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_acc   = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic acc,
                        input logic clr, input logic [7:0] exp);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_acc   = acc;
        bus.acc_clr  = clr;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(mk(exp));
                done = 1'b1;
            end else begin
                retries++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
    } vec_t;

    vec_t tput[10];
    int n0;

    initial begin
        tput[0] = '{8'hFF, 8'h0F, OP_AND,  8'h0F};
        tput[1] = '{8'h12, 8'h34, OP_OR,   8'h36};
        tput[2] = '{8'hAA, 8'h55, OP_XOR,  8'hFF};
        tput[3] = '{8'hFF, 8'hFF, OP_NAND, 8'h00};
        tput[4] = '{8'h01, 8'h02, OP_NOR,  8'hFC};
        tput[5] = '{8'h5A, 8'h5A, OP_XNOR, 8'hFF};
        tput[6] = '{8'hF0, 8'h30, OP_ANDN, 8'hC0};
        tput[7] = '{8'h3C, 8'h00, OP_NOTA, 8'hC3};
        tput[8] = '{8'h81, 8'h18, OP_OR,   8'h99};
        tput[9] = '{8'hC3, 8'h0F, OP_XOR,  8'hCC};

        idle();
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_acc", 32'(dut.acc_q), 0);
        chk("rst_out_zero", 32'(bus.out_zero), 0);
        chk("rst_out_parity", 32'(bus.out_parity), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'hF0, 8'h3C, OP_AND,  1'b0, 1'b0, 8'h30);
        send(8'hF0, 8'h3C, OP_XOR,  1'b0, 1'b0, 8'hCC);
        send(8'hF0, 8'h3C, OP_NOR,  1'b0, 1'b0, 8'h03);
        send(8'hF0, 8'h3C, OP_NOTA, 1'b0, 1'b0, 8'h0F);
        send(8'h0F, 8'hF0, OP_AND,  1'b0, 1'b0, 8'h00);
        send(8'h07, 8'h00, OP_OR,   1'b0, 1'b0, 8'h07);
        idle();

        bus.acc_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
        send(8'hEE, 8'h01, OP_OR,  1'b1, 1'b0, 8'h01);
        send(8'hEE, 8'h80, OP_OR,  1'b1, 1'b0, 8'h81);
        send(8'hEE, 8'hFF, OP_XOR, 1'b1, 1'b0, 8'h7E);
        send(8'hEE, 8'h05, OP_OR,  1'b1, 1'b1, 8'h05);
        send(8'hEE, 8'h00, OP_OR,  1'b1, 1'b0, 8'h05);
        idle();
        repeat (3) @(posedge clk);
        #1;

        n0 = n_xfer;
        bus.out_ready = 1'b0;
        send(8'hF0, 8'h3C, OP_AND, 1'b0, 1'b0, 8'h30);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_XOR;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_hold", 32'(bus.out_data), 32'h30);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.in_ready), 1);
        q.push_back(mk(8'hCC));
        @(posedge clk);
        #1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_transfers", 32'(n_xfer - n0), 2);

        n0 = n_xfer;
        retries = 0;
        foreach (tput[i]) begin
            send(tput[i].a, tput[i].b, tput[i].op, 1'b0, 1'b0, tput[i].y);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("tput_stalls", 32'(retries), 0);
        chk("tput_transfers", 32'(n_xfer - n0), 10);
        chk("total_txn_cnt", 32'(bus.txn_cnt), 32'd23);
        chk("wrap_txn_cnt4", 32'(bus4.txn_cnt), 32'd7);

        bus.out_ready = 1'b0;
        send(8'h0F, 8'h00, OP_OR, 1'b0, 1'b0, 8'h0F);
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_out_data", 32'(bus.out_data), 0);
        chk("mid_rst_acc", 32'(dut.acc_q), 0);
        chk("mid_rst_txn_cnt", 32'(bus.txn_cnt), 0);
        chk("mid_rst_txn_cnt4", 32'(bus4.txn_cnt), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'hEE, 8'h00, OP_OR,  1'b1, 1'b0, 8'h00);
        send(8'hEE, 8'hA5, OP_XOR, 1'b1, 1'b0, 8'hA5);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_txn_cnt", 32'(bus.txn_cnt), 2);
        chk("drain", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_unit.md
Name: logic_op_unit

Overview:
- Parametrised, registered successor to the team's single-bit logical-operator block.
- Applies one of eight bitwise operations to WIDTH-bit operands per transaction, with valid/ready handshakes on both sides and a 1-cycle registered output.
- Has an accumulator mode that chains results: the previous result replaces operand A.
- Has a wrapping transaction counter.
- Sits between a register-file or stimulus source and downstream datapath logic that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of completed-transaction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  unit can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  opcode.
- in_acc  in  1  use accumulator instead of in_a.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  result.
- txn_cnt  out  CNT_W  count of completed output handshakes.
- out_zero  out  1  result == 0 (flags feature only).
- out_parity  out  1  XOR-reduce of result (flags feature only).

Behaviour:
- Opcodes, with A = in_acc ? acc : in_a:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 ANDN (A & ~B), 7 NOTA (~A, B ignored).
  - All operations are bitwise over the full WIDTH; no width extension.
- Reset (async assert, sync release): out_valid=0, out_data=0, acc=0, txn_cnt=0, out_zero=0, out_parity=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready. On accept, the result is registered into out_data and out_valid=1 on the next edge. Latency is 1 cycle.
  - Output transfer = out_valid && out_ready. If transfer and no accept in the same cycle, out_valid goes to 0 next edge.
  - Transfer and accept in the same cycle: out_data takes the new result and out_valid stays 1, giving full throughput of one transaction per cycle.
  - While out_valid && !out_ready, out_data and the flags hold stable and no input is accepted.
- State: two implicit states, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on transfer without accept.
  - FULL->FULL on transfer with accept, or on stall.
- Accumulator:
  - acc <= result on every accept, whether or not in_acc is set.
  - acc_clr=1 forces acc to 0 next edge.
  - acc_clr together with an accept that has in_acc=1: the operation uses 0 as A, and acc ends at that result. The accept's update takes priority over the clear; the clear only wins when there is no accept.
- txn_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- in_op, in_a, in_b and in_acc are don't-care when in_valid=0.
- Reset mid-operation discards a held result. No transfer is reported for it, and txn_cnt is not incremented.

Optional Feature:
- Macro: LOGIC_OP_FLAGS_EN.
- Defined: out_zero = (result == 0) and out_parity = ^result. Both are registered alongside out_data, so they are valid with out_valid and held stable under stall.
- Undefined: the flag registers are not built; out_zero and out_parity are tied to 0. The port list is unchanged.

Decomposition:
- Shared package logic_op_pkg holds:
  - the 3-bit opcode typedef/localparams OP_AND..OP_NOTA (values 0-7);
  - the OPCODE_W=3 constant.
- One sub-module, logic_op_alu: purely combinational WIDTH-bit operation select from (a, b, op).
- The top level holds the handshake register stage, the accumulator and the counter.

Test Plan:
- WIDTH=8, out_ready=1:
  - in_a=0xF0, in_b=0x3C, op AND -> out_data=0x30 one cycle after accept.
  - op XOR -> 0xCC.
  - op NOR -> 0x03.
  - op NOTA -> 0x0F.
- Accumulator:
  - acc_clr pulse, then in_acc=1 OR b=0x01 -> 0x01.
  - OR b=0x80 -> 0x81.
  - XOR b=0xFF -> 0x7E.
  - acc_clr with in_acc=1 OR b=0x05 in the same cycle -> 0x05.
- Backpressure:
  - out_ready=0, two back-to-back offers -> first result held stable and in_ready=0.
  - Second offer is accepted only in the cycle out_ready=1; exactly 2 transfers; txn_cnt=2.
- Throughput: 10 consecutive valid inputs with out_ready=1 -> 10 results on 10 consecutive cycles, in order, txn_cnt=10.
- Counter wrap: CNT_W=4, 17 transfers -> txn_cnt=1.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and stalled -> out_valid, out_data, acc and txn_cnt read 0 immediately, before the next clock edge.
- Flags (with LOGIC_OP_FLAGS_EN): AND 0x0F, 0xF0 -> out_zero=1, out_parity=0. OR 0x07, 0x00 -> out_zero=0, out_parity=1.
